// File: rtl/bless_router_param_if.sv
// Port bundle of bless_router_param: four mesh ports, local inject/eject, deflection statistics.
interface bless_router_param_if #(
    parameter int COORD_W   = 3,
    parameter int AGE_W     = 8,
    parameter int PAYLOAD_W = 32
);
    localparam int FLIT_W = 1 + AGE_W + 2 * COORD_W + PAYLOAD_W;

    logic [FLIT_W-1:0] din_w, din_e, din_s, din_n;
    logic [FLIT_W-1:0] dout_w, dout_e, dout_s, dout_n;
    logic [FLIT_W-2:0] inj_data;
    logic              inj_valid;
    logic              inj_ready;
    logic [FLIT_W-1:0] ej_data;
    logic [15:0]       defl_cnt;

    modport master (
        output din_w, din_e, din_s, din_n, inj_data, inj_valid,
        input  dout_w, dout_e, dout_s, dout_n, inj_ready, ej_data, defl_cnt
    );

    modport slave (
        input  din_w, din_e, din_s, din_n, inj_data, inj_valid,
        output dout_w, dout_e, dout_s, dout_n, inj_ready, ej_data, defl_cnt
    );
endinterface

// File: rtl/bless_router_param.sv
// Bufferless deflection router, oldest-first allocation, 2-stage pipeline.
// Define SIDE_BUF_EN to add a side-buffer FIFO that withholds one deflected flit per cycle.
module bless_router_param #(
    parameter int X_ID      = 0,
    parameter int Y_ID      = 0,
    parameter int COORD_W   = 3,
    parameter int AGE_W     = 8,
    parameter int PAYLOAD_W = 32,
    parameter int SB_DEPTH  = 4
) (
    input logic clk,
    input logic reset,
    bless_router_param_if.slave bus
);
    localparam int FLIT_W   = 1 + AGE_W + 2 * COORD_W + PAYLOAD_W;
    localparam int AGE_LSB  = 2 * COORD_W + PAYLOAD_W;
    localparam int XDST_LSB = COORD_W + PAYLOAD_W;
    localparam logic [AGE_W-1:0]   AGE_MAX = '1;
    localparam logic [COORD_W-1:0] X_C     = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_C     = COORD_W'(Y_ID);

    typedef logic [FLIT_W-1:0] flit_t;
    // Output port indices follow the deflection search order E, W, N, S.
    typedef enum logic [2:0] {PORT_E, PORT_W, PORT_N, PORT_S, PORT_EJ} portT;

    function automatic logic [AGE_W-1:0] ageOf(flit_t f);
        return f[AGE_LSB +: AGE_W];
    endfunction

    function automatic portT routeOf(flit_t f);
        logic [COORD_W-1:0] xd, yd;
        xd = f[XDST_LSB +: COORD_W];
        yd = f[PAYLOAD_W +: COORD_W];
        if (xd > X_C)      return PORT_E;
        else if (xd < X_C) return PORT_W;
        else if (yd > Y_C) return PORT_N;
        else if (yd < Y_C) return PORT_S;
        else               return PORT_EJ;
    endfunction

    function automatic flit_t ageInc(flit_t f);
        logic [AGE_W-1:0] a;
        a = ageOf(f);
        if (a != AGE_MAX) a = a + AGE_W'(1);
        return {f[FLIT_W-1], a, f[AGE_LSB-1:0]};
    endfunction

    flit_t       stage1 [5];      // slots W, E, S, N, Local = tie-break priority
    flit_t       localNext, sbHead;
    flit_t       outFlit [4];
    flit_t       doutNext [4];
    flit_t       ejFlit;
    logic [2:0]  rank [5];
    logic [2:0]  dinValidCnt, deflNum;
    logic [4:0]  deflected;
    logic [3:0]  portFree;
    logic [1:0]  lastDeflPort;
    logic        haveDefl, ejTaken, found;
    portT        route;
    logic [16:0] cntSum;
    logic [15:0] cntNext;
    logic        sbEmpty, sbFull, sbPush, sbPop;
    logic        unusedInjAge;

    assign unusedInjAge = ^bus.inj_data[FLIT_W-2:AGE_LSB];

    assign dinValidCnt = 3'(bus.din_w[FLIT_W-1]) + 3'(bus.din_e[FLIT_W-1])
                       + 3'(bus.din_s[FLIT_W-1]) + 3'(bus.din_n[FLIT_W-1]);
    assign sbPop         = !sbEmpty && (dinValidCnt < 3'd4);
    assign bus.inj_ready = reset && (dinValidCnt < 3'd4) && !sbPop;

    always_comb begin
        if (sbPop)
            localNext = sbHead;
        else if (bus.inj_valid && bus.inj_ready)
            localNext = {1'b1, AGE_W'(0), bus.inj_data[AGE_LSB-1:0]};
        else
            localNext = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++) stage1[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            stage1[0] <= bus.din_w;
            stage1[1] <= bus.din_e;
            stage1[2] <= bus.din_s;
            stage1[3] <= bus.din_n;
            stage1[4] <= localNext;
        end
    end

    // Rank = number of valid flits that are older, or equally old in a higher-priority slot.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rank[i] = '0;
            for (int j = 0; j < 5; j++)
                if (j != i && stage1[j][FLIT_W-1] &&
                    (ageOf(stage1[j]) > ageOf(stage1[i]) ||
                     (ageOf(stage1[j]) == ageOf(stage1[i]) && j < i)))
                    rank[i] = rank[i] + 3'd1;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        portFree     = '1;
        ejTaken      = 1'b0;
        ejFlit       = '0;
        deflected    = '0;
        haveDefl     = 1'b0;
        lastDeflPort = '0;
        found        = 1'b0;
        route        = PORT_EJ;
        for (int p = 0; p < 4; p++) outFlit[p] = '0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) begin
                if (stage1[i][FLIT_W-1] && rank[i] == 3'(r)) begin
                    route = routeOf(stage1[i]);
                    if (route == PORT_EJ && !ejTaken) begin
                        ejTaken = 1'b1;
                        ejFlit  = stage1[i];
                    end else if (route != PORT_EJ && portFree[route[1:0]]) begin
                        outFlit[route[1:0]]  = stage1[i];
                        portFree[route[1:0]] = 1'b0;
                    end else begin
                        deflected[i] = 1'b1;
                        haveDefl     = 1'b1;
                        found        = 1'b0;
                        for (int p = 0; p < 4; p++) begin
                            if (!found && portFree[p]) begin
                                found        = 1'b1;
                                outFlit[p]   = stage1[i];
                                portFree[p]  = 1'b0;
                                lastDeflPort = 2'(p);
                            end
                        end
                    end
                end
            end
        end
        deflNum = '0;
        for (int i = 0; i < 5; i++) deflNum = deflNum + 3'(deflected[i]);
    end

    // Rank order makes the last deflection found the lowest-ranked one.
    assign sbPush = haveDefl && !sbFull;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            if (outFlit[p][FLIT_W-1] && !(sbPush && lastDeflPort == 2'(p)))
                doutNext[p] = ageInc(outFlit[p]);
            else
                doutNext[p] = '0;
        end
        cntSum  = {1'b0, bus.defl_cnt} + 17'(deflNum);
        cntNext = cntSum[16] ? 16'hFFFF : cntSum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dout_e   <= '0;
            bus.dout_w   <= '0;
            bus.dout_n   <= '0;
            bus.dout_s   <= '0;
            bus.ej_data  <= '0;
            bus.defl_cnt <= '0;
        end else begin
            bus.dout_e   <= doutNext[PORT_E];
            bus.dout_w   <= doutNext[PORT_W];
            bus.dout_n   <= doutNext[PORT_N];
            bus.dout_s   <= doutNext[PORT_S];
            bus.ej_data  <= ejFlit;
            bus.defl_cnt <= cntNext;
        end
    end

`ifdef SIDE_BUF_EN
    localparam int SB_AW = $clog2(SB_DEPTH);

    flit_t          sbMem [SB_DEPTH];
    logic [SB_AW:0] sbWrPtr, sbRdPtr;

    assign sbEmpty = (sbWrPtr == sbRdPtr);
    assign sbFull  = (sbWrPtr[SB_AW] != sbRdPtr[SB_AW]) &&
                     (sbWrPtr[SB_AW-1:0] == sbRdPtr[SB_AW-1:0]);
    assign sbHead  = sbMem[sbRdPtr[SB_AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sbWrPtr <= '0;
            sbRdPtr <= '0;
            // NOTE: the storage itself is cleared because stale entries must never reach the local slot.
            for (int i = 0; i < SB_DEPTH; i++) sbMem[i] <= '0;
        end else begin
            if (sbPush) begin
                sbMem[sbWrPtr[SB_AW-1:0]] <= outFlit[lastDeflPort];
                sbWrPtr <= sbWrPtr + (SB_AW+1)'(1);
            end
            if (sbPop) sbRdPtr <= sbRdPtr + (SB_AW+1)'(1);
        end
    end
`else
    localparam int unusedSbDepth = SB_DEPTH;

    assign sbEmpty = 1'b1;
    assign sbFull  = 1'b1;
    assign sbHead  = '0;
`endif
endmodule

// File: tb/tb_bless_router_param.sv
// Scoreboard bench for bless_router_param at X_ID=1, Y_ID=1 with directed vectors.
module tb_bless_router_param;
    localparam int COORD_W   = 3;
    localparam int AGE_W     = 8;
    localparam int PAYLOAD_W = 32;
    localparam int FLIT_W    = 1 + AGE_W + 2 * COORD_W + PAYLOAD_W;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct {
        flit_t       e, w, s, n, ej;
        logic [15:0] cnt;
        int          due;
        bit          chk;
    } expT;

    logic clk;
    logic reset;
    int   edgeCnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   expCnt  = 0;
    expT  expQ[$];

    bless_router_param_if #(.COORD_W(COORD_W), .AGE_W(AGE_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    bless_router_param #(
        .X_ID(1), .Y_ID(1), .COORD_W(COORD_W), .AGE_W(AGE_W),
        .PAYLOAD_W(PAYLOAD_W), .SB_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    function automatic flit_t mk(input int age, input int xd, input int yd, input logic [31:0] pl);
        return {1'b1, 8'(age), 3'(xd), 3'(yd), pl};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Applies one cycle of stimulus and queues the response due two edges later.
    task automatic drive(input flit_t w, e, s, n, input flit_t inj, input logic injV,
                         input logic expRdy, input flit_t xe, xw, xs, xn, xej,
                         input int defl, input bit chk);
        expT x;
        bus.din_w     = w;
        bus.din_e     = e;
        bus.din_s     = s;
        bus.din_n     = n;
        bus.inj_data  = inj[FLIT_W-2:0];
        bus.inj_valid = injV;
        #1;
        if (chk) check("inj_ready", 64'(bus.inj_ready), 64'(expRdy));
        expCnt = (expCnt + defl > 32'hFFFF) ? 32'hFFFF : expCnt + defl;
        x.e   = xe;
        x.w   = xw;
        x.s   = xs;
        x.n   = xn;
        x.ej  = xej;
        x.cnt = 16'(expCnt);
        x.due = edgeCnt + 2;
        x.chk = chk;
        expQ.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        expT x;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].due <= edgeCnt) begin
                x = expQ.pop_front();
                if (x.chk) begin
                    check("dout_e", 64'(bus.dout_e), 64'(x.e));
                    check("dout_w", 64'(bus.dout_w), 64'(x.w));
                    check("dout_s", 64'(bus.dout_s), 64'(x.s));
                    check("dout_n", 64'(bus.dout_n), 64'(x.n));
                    check("ej_data", 64'(bus.ej_data), 64'(x.ej));
                    check("defl_cnt", 64'(bus.defl_cnt), 64'(x.cnt));
                end
            end
        end
    end

`ifdef SIDE_BUF_EN
    task automatic runSideBuf();
        // Four age-0 eastbound flits per cycle: W wins E, E->W, S->N, N->S is withheld.
        for (int c = 0; c < 3; c++)
            drive(mk(0, 3, 1, 32'hA0 + 16 * c), mk(0, 3, 1, 32'hA1 + 16 * c),
                  mk(0, 3, 1, 32'hA2 + 16 * c), mk(0, 3, 1, 32'hA3 + 16 * c), '0, 1'b0, 1'b0,
                  mk(1, 3, 1, 32'hA0 + 16 * c), mk(1, 3, 1, 32'hA1 + 16 * c), '0,
                  mk(1, 3, 1, 32'hA2 + 16 * c), '0, 3, 1'b1);
        // Withheld flits drain through the local slot, oldest first, with age 0 -> 1.
        for (int c = 0; c < 3; c++)
            drive('0, '0, '0, '0, '0, 1'b1, 1'b0,
                  mk(1, 3, 1, 32'hA3 + 16 * c), '0, '0, '0, '0, 0, 1'b1);
        drive('0, '0, '0, '0, '0, 1'b0, 1'b1, '0, '0, '0, '0, '0, 0, 1'b1);
    endtask
`else
    task automatic runBase();
        flit_t injF;
        injF = mk(8'h55, 1, 0, 32'hD4);
        // Single eastbound flit.
        drive(mk(5, 3, 1, 32'hA1), '0, '0, '0, '0, 1'b0, 1'b1,
              mk(6, 3, 1, 32'hA1), '0, '0, '0, '0, 0, 1'b1);
        // Two eject-bound flits: oldest ejects, the other deflects to E.
        drive(mk(9, 1, 1, 32'hB1), mk(4, 1, 1, 32'hB2), '0, '0, '0, 1'b0, 1'b1,
              mk(5, 1, 1, 32'hB2), '0, '0, '0, mk(9, 1, 1, 32'hB1), 1, 1'b1);
        // Four productive flits block injection.
        drive(mk(2, 2, 1, 32'hC1), mk(2, 0, 1, 32'hC2), mk(2, 1, 2, 32'hC3), mk(2, 1, 0, 32'hC4),
              injF, 1'b1, 1'b0,
              mk(3, 2, 1, 32'hC1), mk(3, 0, 1, 32'hC2), mk(3, 1, 0, 32'hC4), mk(3, 1, 2, 32'hC3),
              '0, 0, 1'b1);
        // Three flits: the pending local flit goes in with age 0 and leaves S with age 1.
        drive(mk(7, 2, 1, 32'hD1), mk(7, 0, 1, 32'hD2), mk(7, 1, 2, 32'hD3), '0,
              injF, 1'b1, 1'b1,
              mk(8, 2, 1, 32'hD1), mk(8, 0, 1, 32'hD2), mk(1, 1, 0, 32'hD4), mk(8, 1, 2, 32'hD3),
              '0, 0, 1'b1);
        // Age order with slot tie-break: E2 wins E, E3 deflects W, E1 deflects N, E4 ejects.
        drive(mk(3, 2, 1, 32'hE1), mk(6, 3, 0, 32'hE2), mk(6, 2, 2, 32'hE3), mk(1, 1, 1, 32'hE4),
              '0, 1'b0, 1'b0,
              mk(7, 3, 0, 32'hE2), mk(7, 2, 2, 32'hE3), '0, mk(4, 2, 1, 32'hE1),
              mk(1, 1, 1, 32'hE4), 2, 1'b1);
        // Age saturates at 255.
        drive(mk(254, 0, 0, 32'hF2), '0, '0, mk(255, 1, 3, 32'hF1), '0, 1'b0, 1'b1,
              '0, mk(255, 0, 0, 32'hF2), '0, mk(255, 1, 3, 32'hF1), '0, 0, 1'b1);
        drive('0, '0, '0, '0, '0, 1'b0, 1'b1, '0, '0, '0, '0, '0, 0, 1'b1);

        // Counter is at 3; 21843 cycles of 3 deflections bring it to 65532.
        for (int i = 0; i < 21843; i++)
            drive(mk(0, 3, 1, 1), mk(0, 3, 1, 2), mk(0, 3, 1, 3), mk(0, 3, 1, 4), '0, 1'b0, 1'b0,
                  '0, '0, '0, '0, '0, 3, 1'b0);
        drive(mk(0, 3, 1, 32'h11), mk(0, 3, 1, 32'h12), mk(0, 3, 1, 32'h13), '0, '0, 1'b0, 1'b1,
              mk(1, 3, 1, 32'h11), mk(1, 3, 1, 32'h12), '0, mk(1, 3, 1, 32'h13), '0, 2, 1'b1);
        drive(mk(0, 3, 1, 32'h21), mk(0, 3, 1, 32'h22), mk(0, 3, 1, 32'h23), '0, '0, 1'b0, 1'b1,
              mk(1, 3, 1, 32'h21), mk(1, 3, 1, 32'h22), '0, mk(1, 3, 1, 32'h23), '0, 2, 1'b1);
        drive(mk(0, 3, 1, 32'h31), mk(0, 3, 1, 32'h32), mk(0, 3, 1, 32'h33), mk(0, 3, 1, 32'h34),
              '0, 1'b0, 1'b0,
              mk(1, 3, 1, 32'h31), mk(1, 3, 1, 32'h32), mk(1, 3, 1, 32'h34), mk(1, 3, 1, 32'h33),
              '0, 3, 1'b1);

        // Reset while a flit sits in stage 1: it is dropped and the counter clears.
        bus.din_w = mk(0, 3, 1, 32'h99);
        bus.din_e = '0;
        bus.din_s = '0;
        bus.din_n = '0;
        @(posedge clk);
        bus.din_w = '0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_dout_e", 64'(bus.dout_e), 64'(0));
        check("midrst_defl_cnt", 64'(bus.defl_cnt), 64'(0));
        @(negedge clk);
        reset  = 1'b1;
        expCnt = 0;
        @(posedge clk);
        #1;
        check("midrst_drop", 64'(bus.dout_e), 64'(0));
        drive('0, '0, '0, '0, '0, 1'b0, 1'b1, '0, '0, '0, '0, '0, 0, 1'b1);
    endtask
`endif

    initial begin
        reset         = 1'b0;
        bus.din_w     = mk(1, 2, 3, 32'h1111);
        bus.din_e     = {1'b0, 46'h1234_5678_9ABC};
        bus.din_s     = {1'b0, 46'h0F0F_0F0F_0F0F};
        bus.din_n     = {1'b0, 46'h3333_3333_3333};
        bus.inj_data  = '1;
        bus.inj_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout_e", 64'(bus.dout_e), 64'(0));
        check("rst_dout_w", 64'(bus.dout_w), 64'(0));
        check("rst_dout_s", 64'(bus.dout_s), 64'(0));
        check("rst_dout_n", 64'(bus.dout_n), 64'(0));
        check("rst_ej_data", 64'(bus.ej_data), 64'(0));
        check("rst_defl_cnt", 64'(bus.defl_cnt), 64'(0));
        check("rst_inj_ready", 64'(bus.inj_ready), 64'(0));

        bus.din_w     = '0;
        bus.din_e     = '0;
        bus.din_s     = '0;
        bus.din_n     = '0;
        bus.inj_valid = 1'b0;
        reset         = 1'b1;
        #1;
        check("idle_inj_ready", 64'(bus.inj_ready), 64'(1));
        @(posedge clk);
        #1;

`ifdef SIDE_BUF_EN
        runSideBuf();
`else
        runBase();
`endif

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(expQ.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
